// File: rtl/uart_tx_stream.sv
// uart_tx_stream
//
// Byte-stream UART transmitter. A stream source pushes bytes into a small
// FIFO over a valid/ready handshake. A serializer pops them and sends each
// one as an 8N1 frame (or 8N2 when STOP_BITS=2), least significant bit first.
// Frames whose bytes are already queued follow each other with no idle gap.
//
// Parameters
//   CLKS_PER_BIT  clock cycles per bit period (>= 2)
//   FIFO_DEPTH    FIFO entries (power of two, >= 2)
//   STOP_BITS     stop bits per frame (1 or 2)
//
// Ports
//   wb_clk_i      in   system clock; all logic uses the rising edge
//   wb_rst_i      in   asynchronous, active-high reset
//   s_tdata       in   byte to transmit
//   s_tvalid      in   s_tdata is valid
//   s_tready      out  FIFO can accept a byte (not full)
//   tx_o          out  serial line, idle high
//   busy_o        out  FIFO not empty or a frame is in flight
//   tx_done_o     out  one-cycle pulse during the last cycle of each frame
//   fifo_count_o  out  number of bytes currently queued

module uart_tx_stream #(
    parameter int CLKS_PER_BIT = 4167,
    parameter int FIFO_DEPTH   = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic                        wb_clk_i,
    input  logic                        wb_rst_i,
    input  logic [7:0]                  s_tdata,
    input  logic                        s_tvalid,
    output logic                        s_tready,
    output logic                        tx_o,
    output logic                        busy_o,
    output logic                        tx_done_o,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count_o
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(CLKS_PER_BIT - 2);
    localparam logic [2:0]        STOP_LAST = 3'(STOP_BITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    // FIFO storage and bookkeeping
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    // Serializer state
    state_t           state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             done_q, done_d;
    logic             baud_last;

    // Readiness depends only on registered occupancy, so a pop on the same
    // edge never lets a push into a full FIFO.
    assign full      = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty     = (count_q == '0);
    assign push      = s_tvalid && !full;
    assign baud_last = (baud_q == BAUD_LAST);

    assign s_tready     = !full;
    assign tx_o         = tx_q;
    assign tx_done_o    = done_q;
    assign fifo_count_o = count_q;
    assign busy_o       = (state_q != IDLE) || !empty;

    // Pointer and occupancy update; simultaneous push and pop leave the
    // count unchanged while both pointers advance.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push) begin
            wptr_d = wptr_q + PTR_W'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Serializer next state. The line value is registered, so each branch
    // sets tx_d to what the line must show during the coming cycle.
    // tx_done is raised one cycle early so the registered pulse lands on the
    // final cycle of the last stop bit.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        done_d  = 1'b0;
        pop     = 1'b0;

        case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                baud_d = '0;
                bit_d  = '0;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = mem[rptr_q];
                    state_d = START;
                    tx_d    = 1'b0;
                end
            end

            START: begin
                if (baud_last) begin
                    baud_d  = '0;
                    state_d = DATA;
                    tx_d    = shift_q[0];
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end

            DATA: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        bit_d   = '0;
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        shift_d = {1'b0, shift_q[7:1]};
                        bit_d   = bit_q + 3'd1;
                        tx_d    = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end

            STOP: begin
                tx_d = 1'b1;
                if ((bit_q == STOP_LAST) && (baud_q == BAUD_PRE)) begin
                    done_d = 1'b1;
                end
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_q == STOP_LAST) begin
                        bit_d = '0;
                        if (!empty) begin
                            pop     = 1'b1;
                            shift_d = mem[rptr_q];
                            state_d = START;
                            tx_d    = 1'b0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                baud_d  = '0;
                bit_d   = '0;
            end
        endcase
    end

    // FIFO data array; contents need no reset because occupancy gates reads.
    always_ff @(posedge wb_clk_i) begin
        if (push) begin
            mem[wptr_q] <= s_tdata;
        end
    end

    // State registers. Reset aborts any frame in flight and drops queued bytes.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

endmodule
